// File: rtl/key_debounce.sv
// Active-low key debouncer: 2-flop synchroniser, 4-state FSM, registered level and strobes.
// Optional long-press strobe is compiled in when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int LONG_CNT     = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_filter,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

  state_t          state;
  logic [DB_W-1:0] cnt;
  logic            sync_meta;
  logic            key_s;
  logic            press_done;
  logic            release_done;

  if (DEBOUNCE_CNT < 2 || LONG_CNT < 2) begin : g_param_check
    $error("key_debounce: DEBOUNCE_CNT and LONG_CNT must both be at least 2");
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_meta <= 1'b1;
      key_s     <= 1'b1;
    end else begin
      sync_meta <= key_in;
      key_s     <= sync_meta;
    end
  end

  assign press_done   = (state == PRESS_DB)   && !key_s && (cnt == DB_MAX);
  assign release_done = (state == RELEASE_DB) &&  key_s && (cnt == DB_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_filter  <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_s) begin
            state <= PRESS_DB;
            cnt   <= '0;
          end
        end
        PRESS_DB: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (press_done) begin
            state      <= PRESSED;
            key_filter <= 1'b0;
            key_press  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (key_s) begin
            state <= RELEASE_DB;
            cnt   <= '0;
          end
        end
        RELEASE_DB: begin
          if (!key_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (release_done) begin
            state       <= IDLE;
            key_filter  <= 1'b1;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_CNT);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CNT - 1);

  logic [LONG_W-1:0] long_cnt;
  logic              long_fired;

  // Counter runs through release bounces; only acceptance of a release (or idle) clears it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_cnt   <= '0;
      long_fired <= 1'b0;
      key_long   <= 1'b0;
    end else if (state == IDLE || state == PRESS_DB || release_done) begin
      long_cnt   <= '0;
      long_fired <= 1'b0;
      key_long   <= 1'b0;
    end else begin
      key_long <= (long_cnt == LONG_MAX) && !long_fired;
      if (long_cnt == LONG_MAX) begin
        long_fired <= 1'b1;
      end else begin
        long_cnt <= long_cnt + 1'b1;
      end
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Randomised + directed bench for key_debounce against a sample-history reference model.
// Long-press expectations follow KEY_LONG_PRESS_EN as compiled.
module tb_key_debounce;
  localparam int D = 10;
  localparam int L = 40;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_filter, key_press, key_release, key_long;

  int checks = 0;
  int failures = 0;

  // model state: last D+3 key_in samples, accepted level, cycles held since press
  logic hist[$];
  logic m_filter;
  logic m_press, m_release, m_long;
  int   m_held;

  key_debounce #(.DEBOUNCE_CNT(D), .LONG_CNT(L)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .key_filter(key_filter), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 3; i++) hist.push_back(1'b1);
    m_filter = 1'b1;
    m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
    m_held = 0;
  endtask

  // A level is accepted once D+1 consecutive samples, ending two edges ago, all agree.
  function automatic bit window_all(input logic v);
    for (int i = 0; i <= D; i++) if (hist[i] !== v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic k);
    hist.push_back(k);
    void'(hist.pop_front());
    m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
    if (m_filter && window_all(1'b0)) begin
      m_filter = 1'b0; m_press = 1'b1; m_held = 0;
    end else if (!m_filter && window_all(1'b1)) begin
      m_filter = 1'b1; m_release = 1'b1;
    end else if (!m_filter) begin
      m_held++;
      if (m_held == L && LONG_EN) m_long = 1'b1;
    end
  endtask

  task automatic step(input logic k);
    key_in = k;
    @(posedge sys_clk);
    #1;
    model_edge(k);
    check_eq("key_filter", int'(key_filter), int'(m_filter));
    check_eq("key_press", int'(key_press), int'(m_press));
    check_eq("key_release", int'(key_release), int'(m_release));
    check_eq("key_long", int'(key_long), int'(m_long));
    check_eq("strobe_excl", int'(key_press & key_release), 0);
  endtask

  initial begin
    int edge_at, long_at, long_pulses, press_at;
    logic lvl;

    model_reset();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_rst_n or negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) step(1'b1);

    // 1: reset mid press-debounce discards progress
    repeat (8) step(1'b0);
    #2 sys_rst_n = 1'b0;
    #1;
    check_eq("rst_filter", int'(key_filter), 1);
    check_eq("rst_press", int'(key_press), 0);
    check_eq("rst_release", int'(key_release), 0);
    check_eq("rst_long", int'(key_long), 0);
    key_in = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    repeat (20) step(1'b1);

    // 2: clean press, acceptance on edge 13
    edge_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0);
      if (key_press === 1'b1 && edge_at < 0) edge_at = i;
    end
    check_eq("press_latency", edge_at, D + 3);
    edge_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (key_release === 1'b1 && edge_at < 0) edge_at = i;
    end
    check_eq("release_latency", edge_at, D + 3);

    // 3: short low run, bounce high, then held
    repeat (6) step(1'b0);
    repeat (2) step(1'b1);
    edge_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0);
      if (key_press === 1'b1 && edge_at < 0) edge_at = i;
    end
    check_eq("bounce_press_latency", edge_at, D + 3);

    // 4: release bounce rejected while pressed
    repeat (3) step(1'b1);
    repeat (15) step(1'b0);
    check_eq("bounce_hold_filter", int'(key_filter), 0);
    repeat (20) step(1'b1);

    // 5: long hold, single long pulse 40 cycles after press
    press_at = -1; long_at = -1; long_pulses = 0;
    for (int i = 1; i <= D + 3 + 60; i++) begin
      step(1'b0);
      if (key_press === 1'b1) press_at = i;
      if (key_long === 1'b1) begin
        long_pulses++;
        long_at = i;
      end
    end
    check_eq("long_pulses", long_pulses, LONG_EN ? 1 : 0);
    if (LONG_EN) check_eq("long_latency", long_at - press_at, L);
    edge_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (key_release === 1'b1 && edge_at < 0) edge_at = i;
    end
    check_eq("long_release_latency", edge_at, D + 3);

    // random bouncy runs, with occasional long holds
    lvl = 1'b1;
    for (int s = 0; s < 250; s++) begin
      int len;
      lvl = ~lvl;
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(30, 60))
                                       : int'($urandom_range(1, 14));
      repeat (len) step(lvl);
    end
    repeat (20) step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
